// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS execute-stage helper units.
//   - DIV_WIDTH   : default datapath width of the divider
//   - div_state_t : divider FSM state encoding
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

endpackage : mips_pkg

// File: rtl/div_sub_step.sv
// ----------------------------------------------------------------------------
// div_sub_step
//   Combinational trial subtract for one restoring-division step.
//   Ports:
//     minuend    in  WIDTH+1  shifted partial remainder
//     subtrahend in  WIDTH    divisor magnitude
//     diff       out WIDTH    minuend - subtrahend (meaningful when ge=1)
//     ge         out 1        minuend >= subtrahend (no borrow)
// ----------------------------------------------------------------------------
module div_sub_step
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);

    logic [WIDTH:0] trial;

    always_comb begin
        trial = minuend - {1'b0, subtrahend};
        diff  = trial[WIDTH-1:0];
        // Bit WIDTH of the trial is the borrow, except when the shifted
        // remainder itself overflowed into bit WIDTH: it then exceeds any
        // WIDTH-bit divisor, so the subtract always succeeds.
        ge    = minuend[WIDTH] | ~trial[WIDTH];
    end

endmodule : div_sub_step

// File: rtl/mips_div_unit.sv
// ----------------------------------------------------------------------------
// mips_div_unit
//   Multi-cycle restoring divider for DIV/DIVU. One shift-subtract step per
//   clock; HI takes the remainder and LO the quotient when done pulses.
//   Ports:
//     clk          in  1      rising-edge clock
//     rst          in  1      synchronous, active-high reset
//     start        in  1      request, accepted only in IDLE
//     is_signed    in  1      1 = DIV (two's complement), 0 = DIVU
//     dividend     in  WIDTH  numerator (rs)
//     divisor      in  WIDTH  denominator (rt)
//     busy         out 1      divide in progress (hazard unit stalls on it)
//     done         out 1      one-cycle pulse, results valid
//     quotient     out WIDTH  -> LO
//     remainder    out WIDTH  -> HI
//     div_by_zero  out 1      divisor was zero; held with the results
//   Timing: start sampled at edge N; busy rises at edge N+1 and done rises at
//   edge N+WIDTH+2 (edge N+1 for a zero divisor). busy and done are registered
//   copies of the FSM state, one cycle behind it.
// ----------------------------------------------------------------------------
module mips_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       next_state;

    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr_q;     // divisor magnitude
    logic [CNT_W-1:0] count;
    logic             neg_quo;    // operand signs differ
    logic             neg_rem;    // remainder takes the dividend sign

    logic             accept;
    logic             divisor_zero;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    logic [WIDTH:0]   step_in;
    logic [WIDTH-1:0] step_diff;
    logic             step_ge;

    // ------------------------------------------------------------------
    // Operand conditioning at accept. The magnitude of the most negative
    // value is the same bit pattern read as unsigned, so WIDTH bits suffice.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        accept       = 1'b0;
        divisor_zero = (divisor == '0);
        dividend_neg = is_signed & dividend[WIDTH-1];
        divisor_neg  = is_signed & divisor[WIDTH-1];
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg  ? -divisor  : divisor;
        // The done-pulse cycle is already IDLE; a start there is still ignored.
        if (state == DIV_IDLE && start && !done) begin
            accept = 1'b1;
        end
    end

    // Shift the top quotient bit into the remainder and try the subtract.
    assign step_in = {rem_q, quo_q[WIDTH-1]};

    div_sub_step #(
        .WIDTH (WIDTH)
    ) u_sub_step (
        .minuend    (step_in),
        .subtrahend (dvsr_q),
        .diff       (step_diff),
        .ge         (step_ge)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    next_state = divisor_zero ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                // count runs WIDTH..1, giving exactly WIDTH steps.
                if (count == CNT_W'(1)) begin
                    next_state = DIV_FIX;
                end
            end
            DIV_FIX:  next_state = DIV_DONE;
            DIV_DONE: next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, result and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working registers are reset along with the outputs so
            // nothing from an aborted divide survives a reset.
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            count       <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == DIV_RUN) || (state == DIV_FIX);
            done <= (state == DIV_DONE);

            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            // Results are final immediately; no iteration.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dividend_mag;
                            dvsr_q  <= divisor_mag;
                            count   <= CNT_W'(WIDTH);
                            neg_quo <= dividend_neg ^ divisor_neg;
                            neg_rem <= dividend_neg;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_q <= step_ge ? step_diff : step_in[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], step_ge};
                    count <= count - 1'b1;
                end
                DIV_FIX: begin
                    // Truncation toward zero: fix signs of the magnitudes.
                    // -2^(W-1) / -1 wraps back to -2^(W-1) with no flag.
                    quotient    <= neg_quo ? -quo_q : quo_q;
                    remainder   <= neg_rem ? -rem_q : rem_q;
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mips_div_unit
